// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 fetch/shift engine: FSM encoding,
// pixel word layout and default panel geometry.
package hub75_pkg;

  localparam int PIX_W     = 24;
  localparam int CH_W      = 8;
  localparam int R_OFS     = 16;
  localparam int G_OFS     = 8;
  localparam int B_OFS     = 0;
  localparam int DEF_COLS  = 64;
  localparam int DEF_ROW_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH_TOP = 3'd1,
    ST_FETCH_BOT = 3'd2,
    ST_LOAD      = 3'd3,
    ST_CLK_HI    = 3'd4,
    ST_TAIL      = 3'd5
  } state_t;

endpackage

// File: rtl/hub75_bitsel.sv
// Picks one bit plane out of each colour channel of a packed pixel word.
module hub75_bitsel
  import hub75_pkg::*;
(
  input  logic [PIX_W-1:0] pix,
  input  logic [2:0]       bit_sel,
  output logic             r,
  output logic             g,
  output logic             b
);

  logic [CH_W-1:0] ch_r;
  logic [CH_W-1:0] ch_g;
  logic [CH_W-1:0] ch_b;

  assign ch_r = pix[R_OFS +: CH_W];
  assign ch_g = pix[G_OFS +: CH_W];
  assign ch_b = pix[B_OFS +: CH_W];

  assign r = ch_r[bit_sel];
  assign g = ch_g[bit_sel];
  assign b = ch_b[bit_sel];

endmodule

// File: rtl/hub75_fetchshift.sv
// Fetches a scan row's top and bottom pixels from the frame buffer and
// shifts the selected bit plane onto the HUB75 data pins, one column per 4 cycles.
module hub75_fetchshift #(
  parameter int COLS   = hub75_pkg::DEF_COLS,
  parameter int COL_W  = $clog2(COLS),
  parameter int ROW_W  = hub75_pkg::DEF_ROW_W,
  parameter int ADDR_W = 1 + ROW_W + COL_W,
  parameter int PIX_W  = hub75_pkg::PIX_W
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        bit_in,
  input  logic [7:0]        row_in,
  output logic              busy,
  output logic              fb_rd_en,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [PIX_W-1:0]  fb_data,
  output logic              r0,
  output logic              g0,
  output logic              b0,
  output logic              r1,
  output logic              g1,
  output logic              b1,
  output logic              pix_clk
);

  import hub75_pkg::*;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);

  state_t           state;
  logic [COL_W-1:0] col;
  logic [COL_W-1:0] col_next;
  logic [ROW_W-1:0] row_q;
  logic [2:0]       bit_q;
  logic             top_r, top_g, top_b;
  logic             sel_top_r, sel_top_g, sel_top_b;
  logic             sel_bot_r, sel_bot_g, sel_bot_b;
  logic             unused_row_bits;

  assign unused_row_bits = ^row_in[7:ROW_W];
  assign col_next        = col + COL_ONE;
  assign busy            = (state != ST_IDLE);

  hub75_bitsel u_bitsel_top (
    .pix     (fb_data),
    .bit_sel (bit_q),
    .r       (sel_top_r),
    .g       (sel_top_g),
    .b       (sel_top_b)
  );

  hub75_bitsel u_bitsel_bot (
    .pix     (fb_data),
    .bit_sel (bit_q),
    .r       (sel_bot_r),
    .g       (sel_bot_g),
    .b       (sel_bot_b)
  );

  // Read strobe and address are registered one state ahead so they are
  // valid throughout FETCH_TOP/FETCH_BOT; read data then lands one state later.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      col      <= '0;
      row_q    <= '0;
      bit_q    <= '0;
      top_r    <= 1'b0;
      top_g    <= 1'b0;
      top_b    <= 1'b0;
      r0       <= 1'b0;
      g0       <= 1'b0;
      b0       <= 1'b0;
      r1       <= 1'b0;
      g1       <= 1'b0;
      b1       <= 1'b0;
      pix_clk  <= 1'b0;
      fb_rd_en <= 1'b0;
      fb_addr  <= '0;
    end else begin
      pix_clk <= (state == ST_CLK_HI);
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            bit_q    <= bit_in;
            row_q    <= row_in[ROW_W-1:0];
            col      <= '0;
            fb_rd_en <= 1'b1;
            fb_addr  <= {1'b0, row_in[ROW_W-1:0], {COL_W{1'b0}}};
            state    <= ST_FETCH_TOP;
          end
        end
        ST_FETCH_TOP: begin
          fb_addr <= {1'b1, row_q, col};
          state   <= ST_FETCH_BOT;
        end
        ST_FETCH_BOT: begin
          fb_rd_en <= 1'b0;
          top_r    <= sel_top_r;
          top_g    <= sel_top_g;
          top_b    <= sel_top_b;
          state    <= ST_LOAD;
        end
        ST_LOAD: begin
          r0    <= top_r;
          g0    <= top_g;
          b0    <= top_b;
          r1    <= sel_bot_r;
          g1    <= sel_bot_g;
          b1    <= sel_bot_b;
          state <= ST_CLK_HI;
        end
        ST_CLK_HI: begin
          if (col == LAST_COL) begin
            state <= ST_TAIL;
          end else begin
            col      <= col_next;
            fb_rd_en <= 1'b1;
            fb_addr  <= {1'b0, row_q, col_next};
            state    <= ST_FETCH_TOP;
          end
        end
        ST_TAIL: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
